// File: rtl/dma_rx_send_sched.sv
// Packet-send scheduler for the DMA RX path: per-channel eligibility, rotating
// round-robin pick, go/ack issue handshake and per-channel in-flight accounting.
module dma_rx_send_sched #(
  parameter int CH_NUM     = 32,
  parameter int CID_WIDTH  = $clog2(CH_NUM),
  parameter int MAX_OUTSTD = 4,
  parameter int OUT_WIDTH  = $clog2(MAX_OUTSTD + 1)
) (
  input  logic                          user_clk,
  input  logic                          reset,
  input  logic [CH_NUM-1:0]             chx_enable,
  input  logic [CH_NUM-1:0]             chx_pkt_req,
  output logic [CH_NUM-1:0]             chx_req_ack,
  output logic                          send_go,
  output logic [CID_WIDTH-1:0]          send_cid,
  input  logic                          send_ack,
  input  logic                          send_done,
  input  logic [CID_WIDTH-1:0]          send_done_cid,
  input  logic                          sched_stop,
  output logic                          sched_busy,
  output logic [CH_NUM*OUT_WIDTH-1:0]   chx_outstd,
  output logic                          err_underflow
);

  localparam int                    CW1      = CID_WIDTH + 1;
  localparam logic [OUT_WIDTH-1:0]  CNT_MAX  = OUT_WIDTH'(MAX_OUTSTD);
  localparam logic [CID_WIDTH:0]    CH_LIM   = CW1'(CH_NUM);
  localparam logic [CID_WIDTH-1:0]  CID_LAST = CID_WIDTH'(CH_NUM - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARB   = 2'd1,
    ISSUE = 2'd2
  } state_t;

  state_t                 state_q;
  state_t                 state_d;
  logic [OUT_WIDTH-1:0]   cnt_q [CH_NUM];
  logic [CID_WIDTH-1:0]   rr_ptr;
  logic [CH_NUM-1:0]      elig;
  logic [CH_NUM-1:0]      elig_rot;
  logic [CH_NUM-1:0]      cnt_zero;
  logic [CH_NUM-1:0]      inc_vec;
  logic [CH_NUM-1:0]      dec_vec;
  logic [CID_WIDTH:0]     win_sum;
  logic [CID_WIDTH-1:0]   win_cid;
  logic                   any_elig;
  logic                   issue_fire;
  logic                   done_oor;

  // Eligibility and round-robin winner selection
  always_comb begin
    for (int i = 0; i < CH_NUM; i++) begin
      elig[i]     = chx_enable[i] & chx_pkt_req[i] & (cnt_q[i] < CNT_MAX);
      cnt_zero[i] = (cnt_q[i] == '0);
    end
  end

  assign any_elig = |elig;
  // Rotating right by rr_ptr puts channel rr_ptr at bit 0, so the lowest set bit wins.
  assign elig_rot = CH_NUM'({elig, elig} >> rr_ptr);

  always_comb begin
    win_sum = {1'b0, rr_ptr};
    for (int j = CH_NUM - 1; j >= 0; j--) begin
      if (elig_rot[j]) win_sum = {1'b0, rr_ptr} + CW1'(j);
    end
    if (win_sum >= CH_LIM) win_sum = win_sum - CH_LIM;
    win_cid = win_sum[CID_WIDTH-1:0];
  end

  assign issue_fire = (state_q == ISSUE) & send_ack;
  assign done_oor   = send_done & ({1'b0, send_done_cid} >= CH_LIM);
  assign inc_vec    = issue_fire ? (CH_NUM'(1) << send_cid) : '0;
  assign dec_vec    = (send_done & ~done_oor) ? (CH_NUM'(1) << send_done_cid) : '0;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (!sched_stop && any_elig) state_d = ARB;
      ARB:     state_d = any_elig ? ISSUE : IDLE;
      ISSUE:   if (send_ack) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Registered control and handshake outputs
  always_ff @(posedge user_clk) begin
    if (reset) begin
      state_q     <= IDLE;
      send_go     <= 1'b0;
      send_cid    <= '0;
      sched_busy  <= 1'b0;
      rr_ptr      <= '0;
      chx_req_ack <= '0;
    end else begin
      state_q     <= state_d;
      send_go     <= (state_d == ISSUE);
      sched_busy  <= (state_d != IDLE);
      chx_req_ack <= inc_vec;
      if (state_q == ARB && any_elig) send_cid <= win_cid;
      if (issue_fire) rr_ptr <= (send_cid == CID_LAST) ? '0 : send_cid + 1'b1;
    end
  end

  // In-flight accounting; a same-cycle issue and completion on one channel cancel out
  always_ff @(posedge user_clk) begin
    if (reset) begin
      err_underflow <= 1'b0;
      for (int i = 0; i < CH_NUM; i++) cnt_q[i] <= '0;
    end else begin
      if (done_oor || |(dec_vec & ~inc_vec & cnt_zero)) err_underflow <= 1'b1;
      for (int i = 0; i < CH_NUM; i++) begin
        if (inc_vec[i] && !dec_vec[i]) begin
          cnt_q[i] <= cnt_q[i] + 1'b1;
        end else if (dec_vec[i] && !inc_vec[i] && !cnt_zero[i]) begin
          cnt_q[i] <= cnt_q[i] - 1'b1;
        end
      end
    end
  end

  always_comb begin
    for (int i = 0; i < CH_NUM; i++) chx_outstd[i*OUT_WIDTH +: OUT_WIDTH] = cnt_q[i];
  end

endmodule
